// File: rtl/i2c_slave_tx.sv
// i2c_slave_tx: open-drain I2C slave transmitter (read-direction responder).
// Oversamples scl/sda on i2c_clk, detects START/STOP, ACKs a matching read
// header and then shifts out producer bytes until the master NACKs or STOPs.
module i2c_slave_tx #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'b1101001,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i2c_clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda_line,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       master_nack,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ACK_ADDR = 3'd2,
    ST_LOAD     = 3'd3,
    ST_TX       = 3'd4,
    ST_RX_ACK   = 3'd5
  } state_e;

  // Input synchronizers plus one history flop per line.
  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_hist_q;
  logic                   sda_hist_q;

  logic scl_cur;
  logic sda_cur;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       byte_done_q, byte_done_d;
  logic       ack_seen_q, ack_seen_d;
  logic       sda_oe_q, sda_oe_d;
  logic       tx_ready_q, tx_ready_d;
  logic       master_nack_q, master_nack_d;
  logic       busy_q, busy_d;

  // Synchronize the bus lines into i2c_clk and keep one cycle of history.
  always_ff @(posedge i2c_clk or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_line};
      scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
      sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_cur   = scl_sync_q[SYNC_STAGES-1];
  assign sda_cur   = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_cur & ~scl_hist_q;
  assign scl_fall  = ~scl_cur & scl_hist_q;
  // START/STOP need scl high on both samples so an scl edge never aliases.
  assign start_det = scl_cur & scl_hist_q & sda_hist_q & ~sda_cur;
  assign stop_det  = scl_cur & scl_hist_q & ~sda_hist_q & sda_cur;

  // Next-state and output decode; START/STOP override any data-edge action.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    byte_done_d   = byte_done_q;
    ack_seen_d    = ack_seen_q;
    sda_oe_d      = sda_oe_q;
    tx_ready_d    = 1'b0;
    master_nack_d = 1'b0;

    if (stop_det) begin
      state_d     = ST_IDLE;
      sda_oe_d    = 1'b0;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
      ack_seen_d  = 1'b0;
    end else if (start_det) begin
      state_d     = ST_ADDR;
      sda_oe_d    = 1'b0;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
      ack_seen_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sda_oe_d = 1'b0;
        end
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_cur};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_done_d = 1'b1;
            end else begin
              byte_done_d = byte_done_q;
            end
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            if ((shift_q[7:1] == SLAVE_ADDR) && shift_q[0]) begin
              sda_oe_d = 1'b1;
              state_d  = ST_ACK_ADDR;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_IDLE;
            end
          end else begin
            state_d = ST_ADDR;
          end
        end
        ST_ACK_ADDR: begin
          // Byte is captured on entry to LOAD so tx_ready (registered) lines
          // up with the LOAD cycle and the producer may advance afterwards.
          if (scl_fall) begin
            state_d    = ST_LOAD;
            shift_d    = tx_valid ? tx_data : 8'hFF;
            tx_ready_d = tx_valid;
          end else begin
            state_d = ST_ACK_ADDR;
          end
        end
        ST_LOAD: begin
          state_d   = ST_TX;
          sda_oe_d  = ~shift_q[7];
          bit_cnt_d = 3'd0;
        end
        ST_TX: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d   = 1'b0;
              bit_cnt_d  = 3'd0;
              ack_seen_d = 1'b0;
              state_d    = ST_RX_ACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            state_d = ST_TX;
          end
        end
        ST_RX_ACK: begin
          if (scl_rise) begin
            if (!sda_cur) begin
              ack_seen_d = 1'b1;
            end else begin
              master_nack_d = 1'b1;
              state_d       = ST_IDLE;
            end
          end else if (scl_fall && ack_seen_q) begin
            ack_seen_d = 1'b0;
            state_d    = ST_LOAD;
            shift_d    = tx_valid ? tx_data : 8'hFF;
            tx_ready_d = tx_valid;
          end else begin
            state_d = ST_RX_ACK;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d == ST_ACK_ADDR) || (state_d == ST_LOAD) ||
             (state_d == ST_TX) || (state_d == ST_RX_ACK);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge i2c_clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      shift_q       <= 8'h00;
      bit_cnt_q     <= 3'd0;
      byte_done_q   <= 1'b0;
      ack_seen_q    <= 1'b0;
      sda_oe_q      <= 1'b0;
      tx_ready_q    <= 1'b0;
      master_nack_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_done_q   <= byte_done_d;
      ack_seen_q    <= ack_seen_d;
      sda_oe_q      <= sda_oe_d;
      tx_ready_q    <= tx_ready_d;
      master_nack_q <= master_nack_d;
      busy_q        <= busy_d;
    end
  end

  // Open-drain: only ever pull low or float.
  assign sda_line    = sda_oe_q ? 1'b0 : 1'bz;
  assign tx_ready    = tx_ready_q;
  assign busy        = busy_q;
  assign master_nack = master_nack_q;
  assign state_out   = state_q;

endmodule
